// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel deserializer.
// SIPO_PARITY_EN (optional) widens the frame by one trailing even-parity bit.
package sipo_pkg;

    typedef enum logic {
        SHIFT = 1'b0,
        PEND  = 1'b1
    } state_t;

    // Frame length in accepted serial bits for a given word width.
    function automatic int frame_len(input int width);
`ifdef SIPO_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

    // Bit counter width; must hold frame_len-1.
    function automatic int cnt_width(input int width);
`ifdef SIPO_PARITY_EN
        return $clog2(width + 1);
`else
        return $clog2(width);
`endif
    endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Modulo-FRAME_LEN counter of accepted serial bits with a terminal-count flag.
module sipo_bit_counter #(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic             last,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(FRAME_LEN - 1);

    assign last = (count == LAST_VAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc) begin
            count <= last ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// Double-buffered serial-in/parallel-out front end feeding a pipo register stage.
// Define SIPO_PARITY_EN to append one even-parity bit per word and expose parity_err.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    input  logic             serial_valid,
    output logic             serial_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready
`ifdef SIPO_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int FRAME = frame_len(WIDTH);
    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state;
    logic   [WIDTH-1:0] shift_reg;
    logic   [WIDTH-1:0] shift_next;
    logic   [WIDTH-1:0] word;
    logic   [CNT_W-1:0] bit_cnt;
    logic               last;
    logic               accept;
    logic               shift_en;
    logic               word_done;

    assign serial_ready = (state == SHIFT);
    assign accept       = serial_valid && serial_ready;
    assign word_done    = accept && last;

    always_comb begin
        shift_next = shift_reg;
        if (MSB_FIRST) begin
            shift_next = {shift_reg[WIDTH-2:0], serial_in};
        end else begin
            shift_next = {serial_in, shift_reg[WIDTH-1:1]};
        end
    end

`ifdef SIPO_PARITY_EN
    logic par_calc;
    logic par_pend;

    // The parity bit never enters shift_reg; the word is already complete when it arrives.
    assign shift_en = accept && !last;
    assign word     = shift_reg;
    assign par_calc = ^{shift_reg, serial_in};
`else
    assign shift_en = accept;
    assign word     = shift_next;
`endif

    sipo_bit_counter #(
        .FRAME_LEN (FRAME),
        .CNT_W     (CNT_W)
    ) u_bit_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept),
        .last  (last),
        .count (bit_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SHIFT;
            shift_reg  <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
`ifdef SIPO_PARITY_EN
            parity_err <= 1'b0;
            par_pend   <= 1'b0;
`endif
        end else begin
            case (state)
                SHIFT: begin
                    if (shift_en) begin
                        shift_reg <= shift_next;
                    end
                    if (word_done) begin
                        if (!data_valid || data_ready) begin
                            data_out   <= word;
                            data_valid <= 1'b1;
`ifdef SIPO_PARITY_EN
                            parity_err <= par_calc;
`endif
                        end else begin
                            // Output slot still occupied: hold the word in shift_reg.
                            state <= PEND;
`ifdef SIPO_PARITY_EN
                            par_pend <= par_calc;
`endif
                        end
                    end else if (data_valid && data_ready) begin
                        data_valid <= 1'b0;
                    end
                end
                PEND: begin
                    if (data_ready) begin
                        data_out <= shift_reg;
                        state    <= SHIFT;
`ifdef SIPO_PARITY_EN
                        parity_err <= par_pend;
`endif
                    end
                end
                default: state <= SHIFT;
            endcase
        end
    end

    bit_cnt_range_a: assert property (@(posedge clk) disable iff (!rst_n)
        bit_cnt <= CNT_W'(FRAME - 1));

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed self-checking bench: one MSB-first and one LSB-first deserializer instance.
module tb_sipo_deserializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       si0 = 1'b0, sv0 = 1'b0, dr0 = 1'b0;
    logic       si1 = 1'b0, sv1 = 1'b0, dr1 = 1'b0;
    logic       sr0, dv0, sr1, dv1;
    logic [7:0] do0, do1;
`ifdef SIPO_PARITY_EN
    logic       pe0, pe1;
`endif

    int         n_checks = 0;
    int         n_fail   = 0;
    bit         cap_en   = 1'b0;
    logic [7:0] cap_q[$];

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk          (clk),
        .rst_n        (rst_n),
        .serial_in    (si0),
        .serial_valid (sv0),
        .serial_ready (sr0),
        .data_out     (do0),
        .data_valid   (dv0),
        .data_ready   (dr0)
`ifdef SIPO_PARITY_EN
        ,
        .parity_err   (pe0)
`endif
    );

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk          (clk),
        .rst_n        (rst_n),
        .serial_in    (si1),
        .serial_valid (sv1),
        .serial_ready (sr1),
        .data_out     (do1),
        .data_valid   (dv1),
        .data_ready   (dr1)
`ifdef SIPO_PARITY_EN
        ,
        .parity_err   (pe1)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
        if (cap_en && dv0) cap_q.push_back(do0);
    endtask

    task automatic send_bit(input int sel, input logic b);
        if (sel == 0) begin sv0 = 1'b1; si0 = b; end
        else          begin sv1 = 1'b1; si1 = b; end
        tick();
        sv0 = 1'b0;
        sv1 = 1'b0;
    endtask

    // seq[7] goes out first; with parity builds an even-parity bit follows.
    task automatic send_seq(input int sel, input logic [7:0] seq);
        for (int i = 7; i >= 0; i--) send_bit(sel, seq[i]);
`ifdef SIPO_PARITY_EN
        send_bit(sel, ^seq);
`endif
    endtask

    task automatic test_reset();
        n_checks += 6;
        if (do0 !== 8'h00) begin n_fail++; $display("FAIL reset_do0 got %h exp 00", do0); end
        if (dv0 !== 1'b0)  begin n_fail++; $display("FAIL reset_dv0 got %b exp 0", dv0); end
        if (sr0 !== 1'b1)  begin n_fail++; $display("FAIL reset_sr0 got %b exp 1", sr0); end
        if (do1 !== 8'h00) begin n_fail++; $display("FAIL reset_do1 got %h exp 00", do1); end
        if (dv1 !== 1'b0)  begin n_fail++; $display("FAIL reset_dv1 got %b exp 0", dv1); end
        if (sr1 !== 1'b1)  begin n_fail++; $display("FAIL reset_sr1 got %b exp 1", sr1); end
`ifdef SIPO_PARITY_EN
        n_checks++;
        if (pe0 !== 1'b0)  begin n_fail++; $display("FAIL reset_pe0 got %b exp 0", pe0); end
`endif
    endtask

    task automatic test_basic_word();
        dr0 = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            send_bit(0, 8'hA5 >> i);
            n_checks++;
            if (dv0 !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid bit %0d got %b exp 0", 7 - i, dv0); end
        end
`ifdef SIPO_PARITY_EN
        send_bit(0, 1'b1);
        send_bit(0, 1'b0);
`else
        send_bit(0, 1'b1);
`endif
        n_checks += 2;
        if (dv0 !== 1'b1)  begin n_fail++; $display("FAIL basic_valid got %b exp 1", dv0); end
        if (do0 !== 8'hA5) begin n_fail++; $display("FAIL basic_data got %h exp a5", do0); end
        tick();
        n_checks += 2;
        if (dv0 !== 1'b0)  begin n_fail++; $display("FAIL basic_valid_drop got %b exp 0", dv0); end
        if (do0 !== 8'hA5) begin n_fail++; $display("FAIL basic_hold got %h exp a5", do0); end
    endtask

    task automatic test_lsb_first();
        dr1 = 1'b1;
        send_seq(1, 8'b1010_0101);
        n_checks += 2;
        if (dv1 !== 1'b1)  begin n_fail++; $display("FAIL lsb_valid1 got %b exp 1", dv1); end
        if (do1 !== 8'hA5) begin n_fail++; $display("FAIL lsb_word1 got %h exp a5", do1); end
        send_seq(1, 8'b1100_0000);
        n_checks += 2;
        if (dv1 !== 1'b1)  begin n_fail++; $display("FAIL lsb_valid2 got %b exp 1", dv1); end
        if (do1 !== 8'h03) begin n_fail++; $display("FAIL lsb_word2 got %h exp 03", do1); end
    endtask

    task automatic test_backpressure();
        dr0 = 1'b0;
        send_seq(0, 8'hCC);
        n_checks += 3;
        if (dv0 !== 1'b1)  begin n_fail++; $display("FAIL bp_first_valid got %b exp 1", dv0); end
        if (do0 !== 8'hCC) begin n_fail++; $display("FAIL bp_first_data got %h exp cc", do0); end
        if (sr0 !== 1'b1)  begin n_fail++; $display("FAIL bp_first_ready got %b exp 1", sr0); end
        send_seq(0, 8'hF0);
        n_checks += 3;
        if (sr0 !== 1'b0)  begin n_fail++; $display("FAIL bp_pend_ready got %b exp 0", sr0); end
        if (do0 !== 8'hCC) begin n_fail++; $display("FAIL bp_pend_data got %h exp cc", do0); end
        if (dv0 !== 1'b1)  begin n_fail++; $display("FAIL bp_pend_valid got %b exp 1", dv0); end
        tick();
        n_checks++;
        if (sr0 !== 1'b0)  begin n_fail++; $display("FAIL bp_pend_hold got %b exp 0", sr0); end
        dr0 = 1'b1;
        tick();
        n_checks += 3;
        if (do0 !== 8'hF0) begin n_fail++; $display("FAIL bp_drain_data got %h exp f0", do0); end
        if (sr0 !== 1'b1)  begin n_fail++; $display("FAIL bp_drain_ready got %b exp 1", sr0); end
        if (dv0 !== 1'b1)  begin n_fail++; $display("FAIL bp_drain_valid got %b exp 1", dv0); end
        tick();
        n_checks++;
        if (dv0 !== 1'b0)  begin n_fail++; $display("FAIL bp_empty_valid got %b exp 0", dv0); end
    endtask

    task automatic test_gaps_back_to_back();
        logic [7:0] words [3];
        int         gap_tab [5];
        int         k;
        words   = '{8'h11, 8'h22, 8'h33};
        gap_tab = '{0, 2, 1, 0, 3};
        k = 0;
        dr0 = 1'b1;
        cap_q.delete();
        cap_en = 1'b1;
        for (int w = 0; w < 3; w++) begin
            for (int i = 7; i >= 0; i--) begin
                for (int g = 0; g < gap_tab[k % 5]; g++) tick();
                k++;
                send_bit(0, words[w][i]);
            end
`ifdef SIPO_PARITY_EN
            send_bit(0, ^words[w]);
`endif
        end
        tick();
        cap_en = 1'b0;
        n_checks++;
        if (cap_q.size() != 3) begin
            n_fail++;
            $display("FAIL gaps_count got %0d exp 3", cap_q.size());
        end
        for (int w = 0; w < 3 && w < cap_q.size(); w++) begin
            n_checks++;
            if (cap_q[w] !== words[w]) begin
                n_fail++;
                $display("FAIL gaps_word%0d got %h exp %h", w, cap_q[w], words[w]);
            end
        end
    endtask

    task automatic test_reset_mid_word();
        dr0 = 1'b1;
        for (int i = 0; i < 5; i++) send_bit(0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        n_checks += 3;
        if (do0 !== 8'h00) begin n_fail++; $display("FAIL rstmid_data got %h exp 00", do0); end
        if (dv0 !== 1'b0)  begin n_fail++; $display("FAIL rstmid_valid got %b exp 0", dv0); end
        if (sr0 !== 1'b1)  begin n_fail++; $display("FAIL rstmid_ready got %b exp 1", sr0); end
        #2 rst_n = 1'b1;
        send_seq(0, 8'h5A);
        n_checks += 2;
        if (dv0 !== 1'b1)  begin n_fail++; $display("FAIL rstmid_after_valid got %b exp 1", dv0); end
        if (do0 !== 8'h5A) begin n_fail++; $display("FAIL rstmid_after_data got %h exp 5a", do0); end
    endtask

`ifdef SIPO_PARITY_EN
    task automatic test_parity();
        dr0 = 1'b1;
        for (int i = 7; i >= 0; i--) send_bit(0, 8'h0F >> i);
        send_bit(0, 1'b0);
        n_checks += 2;
        if (do0 !== 8'h0F) begin n_fail++; $display("FAIL par_ok_data got %h exp 0f", do0); end
        if (pe0 !== 1'b0)  begin n_fail++; $display("FAIL par_ok_err got %b exp 0", pe0); end
        for (int i = 7; i >= 0; i--) send_bit(0, 8'h0F >> i);
        send_bit(0, 1'b1);
        n_checks += 2;
        if (do0 !== 8'h0F) begin n_fail++; $display("FAIL par_bad_data got %h exp 0f", do0); end
        if (pe0 !== 1'b1)  begin n_fail++; $display("FAIL par_bad_err got %b exp 1", pe0); end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        #2 rst_n = 1'b1;
        tick();
        test_basic_word();
        test_lsb_first();
        test_backpressure();
        test_gaps_back_to_back();
        test_reset_mid_word();
`ifdef SIPO_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout exceeded 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
